// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_t : arbiter FSM states
//   idx_w()     : width of a requester index, never less than 1 bit
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: returns the first asserted request at or after
// rr_ptr, wrapping modulo NREQ.
//   req_valid in  NREQ   request vector
//   rr_ptr    in  IDX_W  highest-priority index this cycle (< NREQ)
//   pick      out IDX_W  chosen index (0 when nothing is valid)
//   any       out 1      at least one request is valid
module uart_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set
    // bit of rot is the winner's offset from rr_ptr.
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                abs_idx;

    assign dbl = {req_valid, req_valid} >> rr_ptr;
    assign rot = dbl[NREQ-1:0];

    always_comb begin
        pick    = '0;
        any     = 1'b0;
        abs_idx = 0;
        // Walk from the far end so the smallest offset is the last write.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                abs_idx = int'(rr_ptr) + k;
                if (abs_idx >= NREQ) begin
                    abs_idx = abs_idx - NREQ;
                end
                pick = IDX_W'(abs_idx);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte-stream requesters. Grants are
// round-robin and held for a whole packet so bytes never interleave; an owner
// that stalls mid-packet loses the grant after TIMEOUT idle cycles.
//   clock         in   system clock
//   resetb        in   async active-low reset
//   req_valid     in   NREQ         byte present on lane i
//   req_data      in   NREQ*DATA_W  lane i = [i*DATA_W +: DATA_W]
//   req_last      in   NREQ         byte on lane i ends its packet
//   req_ready     out  NREQ         one-hot accept strobe
//   tx_start      out  send tx_data to the UART core
//   tx_data       out  DATA_W       registered byte
//   tx_busy       in   UART frame in progress
//   grant_active  out  a packet owns the UART
//   grant_id      out  IDX_W        owner index
//   timeout_pulse out  one-cycle pulse on forced release
//
// state     | meaning
// IDLE      | no owner; arbitrate among valid requesters
// START     | tx_start high until the UART reports busy
// WAIT_DONE | frame in flight; wait for tx_busy to fall
// HOLD      | mid-packet; wait for the owner's next byte or time out
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int DATA_W  = 8,
    parameter  int TIMEOUT = 1024,
    localparam int IDX_W   = idx_w(NREQ)
) (
    input  logic                   clock,
    input  logic                   resetb,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   tx_start,
    output logic [DATA_W-1:0]      tx_data,
    input  logic                   tx_busy,
    output logic                   grant_active,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   timeout_pulse
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  pick;
    logic              any;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              accept;
    logic [IDX_W-1:0]  next_ptr;
    logic [TMR_W-1:0]  timer;
    logic              last_q;

    uart_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .pick      (pick),
        .any       (any)
    );

    // One lane is of interest at a time: the arbitration winner in IDLE,
    // the owner everywhere else.
    assign sel_idx = (state == IDLE) ? pick : grant_id;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // In IDLE sel_valid is only set when the picker found someone, so a
    // single term covers both accept points.
    assign accept = resetb && sel_valid && (state == IDLE || state == HOLD);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (sel_idx == IDX_W'(i));
        end
    end

    assign next_ptr = IDX_W'((int'(grant_id) + 1) % NREQ);

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            tx_start      <= 1'b0;
            tx_data       <= '0;
            grant_active  <= 1'b0;
            grant_id      <= '0;
            timeout_pulse <= 1'b0;
            timer         <= '0;
            last_q        <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_data      <= sel_data;
                        last_q       <= sel_last;
                        grant_id     <= pick;
                        grant_active <= 1'b1;
                        tx_start     <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            rr_ptr       <= next_ptr;
                            grant_active <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            timer <= '0;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // A byte arriving on the expiry cycle keeps the grant.
                    if (accept) begin
                        tx_data  <= sel_data;
                        last_q   <= sel_last;
                        timer    <= '0;
                        tx_start <= 1'b1;
                        state    <= START;
                    end else if (timer == TMR_LAST) begin
                        timeout_pulse <= 1'b1;
                        rr_ptr        <= next_ptr;
                        grant_active  <= 1'b0;
                        timer         <= '0;
                        state         <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
